// File: rtl/keygen_out_sequencer_if.sv
// Keygen output-stream bundle: command, producer sources, consumer stream and status.
// master = keygen datapath/top-level side, slave = keygen_out_sequencer.
interface keygen_out_sequencer_if #(
  parameter int WORD_W = 64
);
  logic [1:0]          cmd_param;
  logic                cmd_isReady;
  logic                cmd_canReceive;
  logic [8*WORD_W-1:0] src_data;
  logic [7:0]          src_isReady;
  logic [7:0]          src_canReceive;
  logic [WORD_W-1:0]   out;
  logic                out_isReady;
  logic                out_canReceive;
  logic                busy;
  logic                done;
  logic                err_param;

  modport master (
    output cmd_param, cmd_isReady, src_data, src_isReady, out_canReceive,
    input  cmd_canReceive, src_canReceive, out, out_isReady, busy, done, err_param
  );

  modport slave (
    input  cmd_param, cmd_isReady, src_data, src_isReady, out_canReceive,
    output cmd_canReceive, src_canReceive, out, out_isReady, busy, done, err_param
  );
endinterface

// File: rtl/keygen_out_sequencer.sv
// Grants the shared keygen out stream to each producer in fixed order, counting words per segment.
// Define KEYGEN_OUT_INTERNALS_EN to also stream the internal E, A and B matrices.
module keygen_out_sequencer #(
  parameter int WORD_W = 64,
  parameter int CNT_W  = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  keygen_out_sequencer_if.slave bus
);

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef logic [CNT_W-1:0] cnt_t;

`ifdef KEYGEN_OUT_INTERNALS_EN
  localparam logic [2:0] LAST_SEG = 3'd7;
`else
  localparam logic [2:0] LAST_SEG = 3'd4;
`endif

  state_e     state_q, state_d;
  logic [2:0] seg_q, seg_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] param_q, param_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [2:0] sel;
  cnt_t       seg_len_words;
  logic       xfer;

  // Segment position -> producer index (0 sk_s, 1 sk_S, 2 seedA, 3 b, 4 pkh, 5 E, 6 A, 7 B).
  function automatic logic [2:0] seg_src(input logic [2:0] seg);
`ifdef KEYGEN_OUT_INTERNALS_EN
    case (seg)
      3'd0:    return 3'd0;
      3'd1:    return 3'd1;
      3'd2:    return 3'd5;
      3'd3:    return 3'd2;
      3'd4:    return 3'd6;
      3'd5:    return 3'd7;
      3'd6:    return 3'd3;
      default: return 3'd4;
    endcase
`else
    case (seg)
      3'd0:    return 3'd0;
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      3'd3:    return 3'd3;
      default: return 3'd4;
    endcase
`endif
  endfunction

  function automatic cnt_t src_len(input logic [2:0] src, input logic [1:0] param);
    case (src)
      3'd0, 3'd4:
        case (param)
          2'd0:    return cnt_t'(2);
          2'd1:    return cnt_t'(3);
          default: return cnt_t'(4);
        endcase
      3'd1, 3'd5, 3'd7:
        case (param)
          2'd0:    return cnt_t'(1280);
          2'd1:    return cnt_t'(1952);
          default: return cnt_t'(2688);
        endcase
      3'd2:        return cnt_t'(2);
      3'd3:
        case (param)
          2'd0:    return cnt_t'(1200);
          2'd1:    return cnt_t'(1952);
          default: return cnt_t'(2688);
        endcase
      default:
        case (param)
          2'd0:    return cnt_t'(102400);
          2'd1:    return cnt_t'(238144);
          default: return cnt_t'(451584);
        endcase
    endcase
  endfunction

  assign sel           = seg_src(seg_q);
  assign seg_len_words = src_len(sel, param_q);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    cnt_d    = cnt_q;
    param_d  = param_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    xfer     = 1'b0;

    bus.cmd_canReceive = 1'b0;
    bus.out            = '0;
    bus.out_isReady    = 1'b0;
    bus.src_canReceive = '0;

    case (state_q)
      S_IDLE: begin
        bus.cmd_canReceive = 1'b1;
        if (bus.cmd_isReady) begin
          if (bus.cmd_param != 2'd3) begin
            param_d = bus.cmd_param;
            seg_d   = '0;
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        // Without the internals build sel never exceeds 4, so grants 7:5 stay 0.
        bus.out                 = bus.src_data[int'(sel)*WORD_W +: WORD_W];
        bus.out_isReady         = bus.src_isReady[sel];
        bus.src_canReceive[sel] = bus.out_canReceive;
        xfer                    = bus.src_isReady[sel] & bus.out_canReceive;
        if (xfer) begin
          if (cnt_q == seg_len_words - cnt_t'(1)) begin
            cnt_d = '0;
            if (seg_q == LAST_SEG) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              seg_d = seg_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      seg_q   <= '0;
      cnt_q   <= '0;
      param_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      param_q <= param_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = done_q;
  assign bus.err_param = err_q;

endmodule

// File: tb/tb_keygen_out_sequencer.sv
// Randomized self-checking bench for keygen_out_sequencer against a queue-based word-order model.
module tb_keygen_out_sequencer;

  localparam int W = 64;

  typedef struct {
    int src;
    int idx;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   prod_cnt [8];

  keygen_out_sequencer_if #(.WORD_W(W)) bus ();

  keygen_out_sequencer #(.WORD_W(W), .CNT_W(19)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference segment lengths from the parameter-set dimensions.
  function automatic int ref_len(input int src, input int p);
    int n;
    n = (p == 0) ? 640 : (p == 1) ? 976 : 1344;
    case (src)
      0, 4:    return p + 2;
      1, 5, 7: return n * 8 * 16 / 64;
      2:       return 2;
      3:       return n * 8 * ((p == 0) ? 15 : 16) / 64;
      default: return n * n / 4;
    endcase
  endfunction

  function automatic logic [63:0] word_of(input int src, input int idx);
    return {8'(src), 8'hA5, 16'h3C3C, 32'(idx)};
  endfunction

  function automatic void ref_order(output int ord [$]);
`ifdef KEYGEN_OUT_INTERNALS_EN
    ord = '{0, 1, 5, 2, 6, 7, 3, 4};
`else
    ord = '{0, 1, 2, 3, 4};
`endif
  endfunction

  task automatic drive(input logic [7:0] sr, input logic oc);
    for (int i = 0; i < 8; i++) bus.src_data[i*W +: W] = word_of(i, prod_cnt[i]);
    bus.src_isReady    = sr;
    bus.out_canReceive = oc;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out"},            bus.out, 64'h0);
    check({tag, "_out_isReady"},    bus.out_isReady, 0);
    check({tag, "_src_canReceive"}, bus.src_canReceive, 8'h00);
    check({tag, "_cmd_canReceive"}, bus.cmd_canReceive, 1);
    check({tag, "_busy"},           bus.busy, 0);
  endtask

  task automatic start_cmd(input int p);
    @(negedge clk);
    drive(8'hFF, 1'b1);
    bus.cmd_param   = 2'(p);
    bus.cmd_isReady = 1'b1;
    #1;
    check_idle_outputs("cmd_cycle");
    @(posedge clk);
    #1;
    if (p < 3) begin
      check("cmd_busy", bus.busy, 1);
      check("cmd_err", bus.err_param, 0);
      check("cmd_canReceive_run", bus.cmd_canReceive, 0);
    end else begin
      check("bad_err_pulse", bus.err_param, 1);
      check("bad_busy", bus.busy, 0);
      @(negedge clk);
      bus.cmd_isReady = 1'b0;
      #1;
      check_idle_outputs("bad_after");
      @(posedge clk);
      #1;
      check("bad_err_cleared", bus.err_param, 0);
      check("bad_still_idle", bus.busy, 0);
    end
  endtask

  // mode 0: all ready; 1: out_canReceive toggles; 2: random handshakes and
  // cmd noise; 3: src 1 withholds data for 50 cycles at its first word.
  task automatic run_stream(input int p, input int mode, input int abort_src, input int abort_idx);
    item_t       q [$];
    int          ord [$];
    item_t       h;
    int          budget;
    int          stall_left;
    logic [7:0]  sr;
    logic [7:0]  grant;
    logic        oc;
    logic        tog;
    logic        xfer;

    ref_order(ord);
    foreach (ord[s]) for (int k = 0; k < ref_len(ord[s], p); k++) q.push_back('{ord[s], k});
    for (int i = 0; i < 8; i++) prod_cnt[i] = 0;
    budget     = 4 * q.size() + 200;
    stall_left = 50;
    tog        = 1'b1;

    while (q.size() > 0) begin
      if (budget == 0) begin
        check("timeout_words_left", 64'(q.size()), 64'h0);
        break;
      end
      budget--;
      @(negedge clk);
      h  = q[0];
      sr = 8'hFF;
      oc = 1'b1;
      bus.cmd_isReady = 1'b0;
      case (mode)
        1: begin oc = tog; tog = ~tog; end
        2: begin
          sr = 8'($urandom) | 8'($urandom);
          oc = ($urandom_range(3) != 0);
          bus.cmd_isReady = 1'($urandom_range(1));
          bus.cmd_param   = 2'($urandom_range(3));
        end
        3: if (h.src == 1 && h.idx == 0 && stall_left > 0) begin
          sr[1] = 1'b0;
          stall_left--;
        end
        default: ;
      endcase
      drive(sr, oc);

      if (h.src == abort_src && h.idx == abort_idx) begin
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        check("abort_done", bus.done, 0);
        check("abort_err", bus.err_param, 0);
        @(posedge clk);
        #1;
        check("abort_no_done", bus.done, 0);
        check("abort_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end

      #1;
      check("out_isReady", bus.out_isReady, sr[h.src]);
      check("src_canReceive", bus.src_canReceive, oc ? (8'h1 << h.src) : 8'h00);
      check("cmd_canReceive_busy", bus.cmd_canReceive, 0);
      xfer = sr[h.src] & oc;
      if (xfer) check("out_word", bus.out, word_of(h.src, h.idx));
      grant = bus.src_canReceive & sr;
      @(posedge clk);
      for (int i = 0; i < 8; i++) if (grant[i]) prod_cnt[i]++;
      if (xfer) void'(q.pop_front());
      #1;
      check("done", bus.done, (q.size() == 0) && xfer);
      check("busy", bus.busy, !((q.size() == 0) && xfer));
      check("err_in_run", bus.err_param, 0);
    end
    bus.cmd_isReady = 1'b0;

    if (abort_src < 0) begin
      check("idle_canReceive_with_done", bus.cmd_canReceive, 1);
      for (int i = 0; i < 8; i++) begin
        int exp_n;
        exp_n = 0;
        foreach (ord[s]) if (ord[s] == i) exp_n = ref_len(i, p);
        check($sformatf("producer%0d_count", i), 64'(prod_cnt[i]), 64'(exp_n));
      end
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus.cmd_param      = 2'd0;
    bus.cmd_isReady    = 1'b0;
    bus.src_data       = '0;
    bus.src_isReady    = '0;
    bus.out_canReceive = 1'b0;
    for (int i = 0; i < 8; i++) prod_cnt[i] = 0;
    #2;
    check_idle_outputs("reset");
    check("reset_done", bus.done, 0);
    check("reset_err", bus.err_param, 0);
    @(negedge clk);
    rst = 1'b0;

    start_cmd(3);
    start_cmd(0);
    run_stream(0, 0, -1, -1);
    start_cmd(2);
    run_stream(2, 1, -1, -1);
    start_cmd(1);
    run_stream(1, 0, 3, 100);
    start_cmd(1);
    run_stream(1, 2, -1, -1);
    start_cmd(0);
    run_stream(0, 3, -1, -1);
    start_cmd(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
